nibble_packer: RTL and testbench
================================

# nibble_packer

Upstream feeder for the five-input max-finder peripheral. It accepts a serial stream of 4-bit samples and packs each group of five into one 20-bit word, least-significant nibble first, which is the operand layout the max-finder's data buffer expects. Packed words are queued in a small show-ahead FIFO. A downstream master drains the FIFO and writes each word into the max-finder.

## Interface
Parameters:
- NIBBLES, 5: nibbles per packed word (word width = 4*NIBBLES).
- DEPTH, 4: FIFO depth in packed words; power of two, at least 2.

Ports:
- iClk  in  1  single clock; all state updates on rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iValid  in  1  iNibble is valid this cycle.
- iNibble  in  4  sample value.
- iFlush  in  1  emit the current partial word, zero-padded.
- iRead  in  1  pop the FIFO head.
- oReady  out  1  the block accepts iValid/iFlush this cycle.
- oWord  out  4*NIBBLES  FIFO head (show-ahead).
- oWordValid  out  1  FIFO not empty.
- oCount  out  clog2(DEPTH+1)  FIFO occupancy, 0..DEPTH.
- oPacked  out  16  total words pushed; wraps modulo 2^16.

## Operation
- **Accumulator:** holds a nibble index k in 0..NIBBLES-1. Accepted nibble k is written to bits [4k+3:4k].
- **Accept:** a nibble is accepted when iValid=1 and oReady=1. Otherwise iNibble is ignored and the accumulator is unchanged.
- **Completion:** when the nibble accepted is at k=NIBBLES-1, the assembled word (including that nibble) is pushed into the FIFO on the same edge. k returns to 0 and the accumulator is cleared.
- **Flush:** sampled only when oReady=1.
  - k>0: push the partial word with unfilled nibbles = 0, then k:=0.
  - k=0 and no nibble accepted this cycle: no-op. Nothing is pushed and oPacked is unchanged.
  - iValid and iFlush together: the nibble is accepted first, and the flush applies to the word that includes it. If that nibble completes the word, only one word is pushed.
- **oReady:** is 0 only when a push would overflow, i.e. the FIFO is full (oCount==DEPTH) and either k==NIBBLES-1 or k>0. Otherwise oReady=1. oReady is a function of registered state only and never of iRead. Consequently, with a full FIFO, nibbles are accepted only at k=0.
- **FIFO:**
  - Circular buffer with read and write pointers, modulo DEPTH.
  - oWord shows mem[rd_ptr].
  - oWordValid = (oCount!=0).
  - iRead with an empty FIFO is ignored.
  - A push and a pop in the same cycle leave oCount unchanged. When full, this case can only be a pop, because oReady=0 blocks the push.
- **oPacked:** increments by 1 on every push.

## Timing
- **Reset (asynchronous, immediate):**
  - k=0, accumulator=0, pointers=0.
  - oCount=0, oWordValid=0, oWord=0, oPacked=0, oReady=1.
  - Reset mid-word discards the partial word. Reset with a non-empty FIFO discards its contents.
- **Push latency:** a word pushed at edge N gives oWordValid=1 and oCount incremented after edge N. oWord shows that word after edge N if the FIFO was empty.
- **Pop:** iRead=1 at edge N advances oWord to the next entry after edge N. If only one entry remained, oWordValid=0 after edge N.
- **Ready recovery:** oReady changes only after a clock edge. A pop at edge N that relieves a full FIFO raises oReady in cycle N+1.
- **Throughput:** one nibble per cycle sustained while the FIFO is not full. One word per NIBBLES cycles.

## Test plan
- **Basic pack:** reset, then nibbles 1,2,3,4,5 on consecutive cycles -> after the 5th edge oWordValid=1, oWord=20'h54321, oCount=1, oPacked=1.
- **Partial flush:** nibbles A,B, then iFlush alone -> oWord=20'h000BA. A second iFlush with k=0 -> no push, oPacked unchanged.
- **Flush with nibble:**
  - Nibbles 1,2,3 plus iFlush together with nibble 4 -> single word 20'h04321.
  - iFlush together with the 5th nibble -> exactly one push.
- **Backpressure (DEPTH=4):**
  - Push 4 words with no reads -> oCount=4.
  - Nibble 7 is accepted at k=0, after which oReady=0. Nibbles held on iValid are not accepted.
  - Pulse iRead -> oCount=3, and oReady=1 the following cycle. The held nibble is then accepted, no data is lost, and FIFO order is preserved.
- **Simultaneous push/pop:** with oCount=2, complete a word on the same edge as iRead -> oCount stays 2, the head advances, and the new word lands at the tail.
- **Reset mid-operation:** 3 nibbles accepted and 2 words queued, then assert iReset_n=0 mid-cycle -> outputs clear immediately. After release, 5 nibbles produce a clean word whose upper nibbles hold none of the stale data.

Source files
------------

// File: rtl/nibble_packer.sv
// ============================================================================
// nibble_packer
//   Packs groups of NIBBLES 4-bit samples (LS nibble first) into words and
//   queues them in a small show-ahead FIFO for the max-finder's buffer master.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_packer #(
    parameter int NIBBLES = 5,
    parameter int DEPTH   = 4
) (
    input  logic                         iClk,
    input  logic                         iReset_n,
    input  logic                         iValid,
    input  logic [3:0]                   iNibble,
    input  logic                         iFlush,
    input  logic                         iRead,
    output logic                         oReady,
    output logic [4*NIBBLES-1:0]         oWord,
    output logic                         oWordValid,
    output logic [$clog2(DEPTH+1)-1:0]   oCount,
    output logic [15:0]                  oPacked
);

    localparam int W  = 4 * NIBBLES;
    localparam int KW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    localparam logic [KW-1:0] C_K_LAST = KW'(NIBBLES - 1);
    localparam logic [CW-1:0] C_FULL   = CW'(DEPTH);

    logic [KW-1:0] k_q,      k_d;
    logic [W-1:0]  acc_q,    acc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic [15:0]   packed_q, packed_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];

    logic          w_full;
    logic          w_ready;
    logic          w_accept;
    logic          w_flush;
    logic          w_pop;
    logic          w_room;
    logic          w_complete;
    logic          w_push;
    logic [W-1:0]  w_assembled;

    assign w_full   = (count_q == C_FULL);
    assign w_ready  = !(w_full && (k_q != '0));
    assign w_accept = iValid && w_ready;
    assign w_flush  = iFlush && w_ready;
    assign w_pop    = iRead && (count_q != '0);
    assign w_room   = !w_full || w_pop;

    always_comb begin
        w_assembled = acc_q;
        for (int i = 0; i < NIBBLES; i++) begin
            if (w_accept && (k_q == KW'(i))) begin
                w_assembled[4*i +: 4] = iNibble;
            end
        end
    end

    // A flush of a lone nibble taken at k=0 into a full FIFO with no pop has
    // nowhere to go, so the nibble is kept as a partial word and oReady drops.
    assign w_complete = w_accept && (k_q == C_K_LAST);
    assign w_push     = w_complete ||
                        (w_flush && ((k_q != '0) || (w_accept && w_room)));

    always_comb begin
        k_d      = k_q;
        acc_d    = acc_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        packed_d = packed_q;
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end

        if (w_push) begin
            k_d             = '0;
            acc_d           = '0;
            mem_d[wr_ptr_q] = w_assembled;
            wr_ptr_d        = wr_ptr_q + AW'(1);
            packed_d        = packed_q + 16'd1;
        end else if (w_accept) begin
            k_d   = k_q + KW'(1);
            acc_d = w_assembled;
        end

        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        if (w_push && !w_pop) begin
            count_d = count_q + CW'(1);
        end else if (w_pop && !w_push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) begin
            k_q      <= '0;
            acc_q    <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            packed_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            k_q      <= k_d;
            acc_q    <= acc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            packed_q <= packed_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

    assign oReady     = w_ready;
    assign oWord      = mem_q[rd_ptr_q];
    assign oWordValid = (count_q != '0);
    assign oCount     = count_q;
    assign oPacked    = packed_q;

endmodule

`default_nettype wire

// File: tb/tb_nibble_packer.sv
// ============================================================================
// tb_nibble_packer
//   Self-checking bench: vector table, directed corner sequences, random run.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_packer;

    localparam int NIBBLES = 5;
    localparam int DEPTH   = 4;

    logic        iClk;
    logic        iReset_n;
    logic        iValid;
    logic [3:0]  iNibble;
    logic        iFlush;
    logic        iRead;
    logic        oReady;
    logic [19:0] oWord;
    logic        oWordValid;
    logic [2:0]  oCount;
    logic [15:0] oPacked;

    int errors = 0;
    int checks = 0;

    nibble_packer #(.NIBBLES(NIBBLES), .DEPTH(DEPTH)) dut (
        .iClk       (iClk),
        .iReset_n   (iReset_n),
        .iValid     (iValid),
        .iNibble    (iNibble),
        .iFlush     (iFlush),
        .iRead      (iRead),
        .oReady     (oReady),
        .oWord      (oWord),
        .oWordValid (oWordValid),
        .oCount     (oCount),
        .oPacked    (oPacked)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Reference model: a list of pending nibbles and a queue of whole words.
    logic [3:0]  m_part [$];
    logic [19:0] m_q    [$];
    logic [15:0] m_packed;

    function automatic logic [19:0] m_compose();
        logic [19:0] w = '0;
        foreach (m_part[i]) w = w | (20'(m_part[i]) << (4 * i));
        return w;
    endfunction

    function automatic logic m_ready();
        return !((m_q.size() == DEPTH) && (m_part.size() != 0));
    endfunction

    task automatic m_reset();
        m_part.delete();
        m_q.delete();
        m_packed = '0;
    endtask

    task automatic m_update(input logic v, input logic [3:0] n, input logic f, input logic r);
        logic rdy;
        logic popped;
        logic emit;
        logic [19:0] w;
        rdy    = m_ready();
        popped = r && (m_q.size() != 0);
        emit   = 1'b0;
        if (v && rdy) m_part.push_back(n);
        if (m_part.size() == NIBBLES) begin
            emit = 1'b1;
        end else if (f && rdy && (m_part.size() != 0)) begin
            // a word is only ever emitted when the FIFO has space for it
            emit = (m_q.size() - (popped ? 1 : 0)) < DEPTH;
        end
        w = m_compose();
        if (popped) void'(m_q.pop_front());
        if (emit) begin
            m_q.push_back(w);
            m_part.delete();
            m_packed = m_packed + 16'd1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_check();
        chk("m_valid",  32'(oWordValid), 32'(m_q.size() != 0));
        chk("m_count",  32'(oCount),     32'(m_q.size()));
        chk("m_packed", 32'(oPacked),    32'(m_packed));
        chk("m_ready",  32'(oReady),     32'(m_ready()));
        if (m_q.size() != 0) chk("m_word", 32'(oWord), 32'(m_q[0]));
    endtask

    task automatic step(input logic v, input logic [3:0] n, input logic f, input logic r);
        iValid  = v;
        iNibble = n;
        iFlush  = f;
        iRead   = r;
        @(posedge iClk);
        m_update(v, n, f, r);
        #1;
        model_check();
        iValid = 1'b0;
        iFlush = 1'b0;
        iRead  = 1'b0;
    endtask

    task automatic push_word(input logic [19:0] w);
        for (int i = 0; i < NIBBLES; i++) begin
            logic [19:0] t = w >> (4 * i);
            step(1'b1, t[3:0], 1'b0, 1'b0);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_valid"},  32'(oWordValid), 32'd0);
        chk({tag, "_count"},  32'(oCount),     32'd0);
        chk({tag, "_word"},   32'(oWord),      32'd0);
        chk({tag, "_packed"}, 32'(oPacked),    32'd0);
        chk({tag, "_ready"},  32'(oReady),     32'd1);
    endtask

    typedef struct {
        logic        v;
        logic [3:0]  n;
        logic        f;
        logic        r;
        logic [19:0] e_word;
        logic        e_valid;
        logic [2:0]  e_count;
        logic [15:0] e_packed;
    } vec_t;

    vec_t vt [22];

    initial begin
        // basic pack 1..5
        vt[0]  = '{1, 4'h1, 0, 0, 20'h0,     0, 3'd0, 16'd0};
        vt[1]  = '{1, 4'h2, 0, 0, 20'h0,     0, 3'd0, 16'd0};
        vt[2]  = '{1, 4'h3, 0, 0, 20'h0,     0, 3'd0, 16'd0};
        vt[3]  = '{1, 4'h4, 0, 0, 20'h0,     0, 3'd0, 16'd0};
        vt[4]  = '{1, 4'h5, 0, 0, 20'h54321, 1, 3'd1, 16'd1};
        vt[5]  = '{0, 4'h0, 0, 1, 20'h0,     0, 3'd0, 16'd1};
        // partial flush, then a no-op flush at k=0
        vt[6]  = '{1, 4'hA, 0, 0, 20'h0,     0, 3'd0, 16'd1};
        vt[7]  = '{1, 4'hB, 0, 0, 20'h0,     0, 3'd0, 16'd1};
        vt[8]  = '{0, 4'h0, 1, 0, 20'h000BA, 1, 3'd1, 16'd2};
        vt[9]  = '{0, 4'h0, 1, 0, 20'h000BA, 1, 3'd1, 16'd2};
        vt[10] = '{0, 4'h0, 0, 1, 20'h0,     0, 3'd0, 16'd2};
        // flush together with the 4th nibble
        vt[11] = '{1, 4'h1, 0, 0, 20'h0,     0, 3'd0, 16'd2};
        vt[12] = '{1, 4'h2, 0, 0, 20'h0,     0, 3'd0, 16'd2};
        vt[13] = '{1, 4'h3, 0, 0, 20'h0,     0, 3'd0, 16'd2};
        vt[14] = '{1, 4'h4, 1, 0, 20'h04321, 1, 3'd1, 16'd3};
        vt[15] = '{0, 4'h0, 0, 1, 20'h0,     0, 3'd0, 16'd3};
        // flush together with the completing nibble: one push only
        vt[16] = '{1, 4'h6, 0, 0, 20'h0,     0, 3'd0, 16'd3};
        vt[17] = '{1, 4'h7, 0, 0, 20'h0,     0, 3'd0, 16'd3};
        vt[18] = '{1, 4'h8, 0, 0, 20'h0,     0, 3'd0, 16'd3};
        vt[19] = '{1, 4'h9, 0, 0, 20'h0,     0, 3'd0, 16'd3};
        vt[20] = '{1, 4'hA, 1, 0, 20'hA9876, 1, 3'd1, 16'd4};
        vt[21] = '{0, 4'h0, 0, 1, 20'h0,     0, 3'd0, 16'd4};
    end

    initial begin
        iReset_n = 1'b0;
        iValid   = 1'b0;
        iNibble  = '0;
        iFlush   = 1'b0;
        iRead    = 1'b0;
        m_reset();
        repeat (2) @(posedge iClk);
        #1;
        check_reset_outputs("reset");
        iReset_n = 1'b1;

        for (int i = 0; i < 22; i++) begin
            step(vt[i].v, vt[i].n, vt[i].f, vt[i].r);
            chk($sformatf("tbl%0d_valid", i),  32'(oWordValid), 32'(vt[i].e_valid));
            chk($sformatf("tbl%0d_count", i),  32'(oCount),     32'(vt[i].e_count));
            chk($sformatf("tbl%0d_packed", i), 32'(oPacked),    32'(vt[i].e_packed));
            if (vt[i].e_valid) chk($sformatf("tbl%0d_word", i), 32'(oWord), 32'(vt[i].e_word));
        end

        // backpressure: fill, then a held nibble must wait for a pop
        push_word(20'h11111);
        push_word(20'h22222);
        push_word(20'h33333);
        push_word(20'h44444);
        chk("bp_full_count", 32'(oCount), 32'd4);
        step(1'b1, 4'h7, 1'b0, 1'b0);
        chk("bp_k0_accept_ready", 32'(oReady), 32'd0);
        step(1'b1, 4'h8, 1'b0, 1'b0);
        step(1'b1, 4'h8, 1'b0, 1'b0);
        chk("bp_held_packed", 32'(oPacked), 32'd8);
        step(1'b1, 4'h8, 1'b0, 1'b1);
        chk("bp_pop_count", 32'(oCount), 32'd3);
        chk("bp_ready_recover", 32'(oReady), 32'd1);
        chk("bp_head_after_pop", 32'(oWord), 32'h22222);
        step(1'b1, 4'h8, 1'b0, 1'b0);
        step(1'b1, 4'h9, 1'b0, 1'b0);
        step(1'b1, 4'hA, 1'b0, 1'b0);
        step(1'b1, 4'hB, 1'b0, 1'b0);
        chk("bp_refill_count", 32'(oCount), 32'd4);
        repeat (3) step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("bp_tail_word", 32'(oWord), 32'hBA987);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("bp_drained", 32'(oWordValid), 32'd0);

        // simultaneous push and pop
        push_word(20'hAAAAA);
        push_word(20'hBBBBB);
        repeat (4) step(1'b1, 4'hC, 1'b0, 1'b0);
        step(1'b1, 4'hC, 1'b0, 1'b1);
        chk("pp_count", 32'(oCount), 32'd2);
        chk("pp_head", 32'(oWord), 32'hBBBBB);
        step(1'b0, 4'h0, 1'b0, 1'b1);
        chk("pp_tail", 32'(oWord), 32'hCCCCC);
        step(1'b0, 4'h0, 1'b0, 1'b1);

        // asynchronous reset mid-word with a loaded FIFO
        push_word(20'hDDDDD);
        push_word(20'hEEEEE);
        repeat (3) step(1'b1, 4'hF, 1'b0, 1'b0);
        #3;
        iReset_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        m_reset();
        @(posedge iClk);
        #2;
        iReset_n = 1'b1;
        repeat (5) step(1'b1, 4'h1, 1'b0, 1'b0);
        chk("post_reset_word", 32'(oWord), 32'h11111);
        chk("post_reset_packed", 32'(oPacked), 32'd1);
        step(1'b1, 4'h2, 1'b1, 1'b1);
        chk("post_reset_flush1", 32'(oWord), 32'h00002);

        // random traffic against the reference model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 70) ? 1'b1 : 1'b0,
                 4'($urandom_range(0, 15)),
                 ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 99) < 35) ? 1'b1 : 1'b0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
